// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow sequencer.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_OVER      = 3'd3,
      ST_RESPAWN   = 3'd4
   } game_state_e;

   localparam int                 SCORE_W    = 16;
   localparam logic [SCORE_W-1:0] SCORE_MAX  = 16'hFFFF;
   localparam logic [1:0]         LIVES_INIT = 2'd3;

   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_MAX) ? s : s + 16'd1;
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Board/datapath-side signal bundle of the game sequencer.
interface game_sequencer_if;
   import game_pkg::*;

   logic               frame_tick;
   logic               btn_start;
   logic               btn_left;
   logic               btn_right;
   logic               fail;
   logic               ball_rst;
   logic               move_left;
   logic               move_right;
   logic               run;
   logic [2:0]         state;
   logic [2:0]         countdown;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] best;
   logic [1:0]         lives;

   modport master (
      output frame_tick, btn_start, btn_left, btn_right, fail,
      input  ball_rst, move_left, move_right, run, state, countdown, score, best, lives
   );

   modport slave (
      input  frame_tick, btn_start, btn_left, btn_right, fail,
      output ball_rst, move_left, move_right, run, state, countdown, score, best, lives
   );
endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse when sig_i goes 0 -> 1.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic pulse_o
);
   logic sig_q;

   always_ff @(posedge clk) begin
      if (!rst) sig_q <= 1'b0;
      else      sig_q <= sig_i;
   end

   assign pulse_o = sig_i & ~sig_q;
endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: idle/countdown/play/over sequencing, fail debounce, scoring.
// Optional macro GAME_LIVES_EN adds a lives counter and the RESPAWN state.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_IDLE      | after reset, ball held in reset, waiting for start edge
//  ST_COUNTDOWN | showing countdown steps, ball held in reset
//  ST_PLAY      | run active, score counting, fail debounced
//  ST_OVER      | run ended, start locked out until hold timer expires
//  ST_RESPAWN   | life lost, next frame restarts the countdown (lives only)
module game_sequencer
   import game_pkg::*;
#(
   parameter int FRAMES_PER_STEP  = 60,
   parameter int COUNT_STEPS      = 3,
   parameter int FAIL_FRAMES      = 2,
   parameter int OVER_HOLD_FRAMES = 120
) (
   input logic             clk,
   input logic             rst,
   game_sequencer_if.slave gif
);
   localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int HW = (OVER_HOLD_FRAMES > 0) ? $clog2(OVER_HOLD_FRAMES + 1) : 1;
   localparam logic [FW-1:0] FRAME_RELOAD = FW'(FRAMES_PER_STEP - 1);
   localparam logic [HW-1:0] HOLD_LOAD    = HW'(OVER_HOLD_FRAMES);
   localparam logic [2:0]    STEP_LOAD    = 3'(COUNT_STEPS);
   localparam logic [3:0]    FAIL_LAST    = 4'(FAIL_FRAMES - 1);

   game_state_e        state_q, state_d;
   logic [2:0]         step_q, step_d;
   logic [FW-1:0]      frame_q, frame_d;
   logic [3:0]         fail_q, fail_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] best_q, best_d;
   logic [1:0]         lives_q, lives_d;
   logic               ball_rst_q, ball_rst_d;
   logic               run_q, run_d;
   logic               move_left_q, move_left_d;
   logic               move_right_q, move_right_d;
   logic [2:0]         countdown_q, countdown_d;

   logic start_edge;
   logic new_game;
   logic load_steps;
   logic end_run;
   logic go_over;

   rise_detect u_start_rise (
      .clk     (clk),
      .rst     (rst),
      .sig_i   (gif.btn_start),
      .pulse_o (start_edge)
   );

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      frame_d    = frame_q;
      fail_d     = fail_q;
      hold_d     = hold_q;
      score_d    = score_q;
      best_d     = best_q;
`ifdef GAME_LIVES_EN
      lives_d    = lives_q;
`else
      lives_d    = 2'd1;
`endif
      new_game   = 1'b0;
      load_steps = 1'b0;
      end_run    = 1'b0;
      go_over    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_edge) new_game = 1'b1;
         end
         ST_COUNTDOWN: begin
            if (gif.frame_tick) begin
               if (frame_q == '0) begin
                  frame_d = FRAME_RELOAD;
                  step_d  = step_q - 3'd1;
                  if (step_q == 3'd1) state_d = ST_PLAY;
               end else begin
                  frame_d = frame_q - 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (gif.frame_tick) begin
               score_d = score_inc(score_q);
               if (gif.fail) begin
                  if (fail_q == FAIL_LAST) end_run = 1'b1;
                  else                     fail_d  = fail_q + 4'd1;
               end else begin
                  fail_d = '0;
               end
            end
         end
         ST_OVER: begin
            if (hold_q != '0) begin
               if (gif.frame_tick) hold_d = hold_q - 1'b1;
            end else if (start_edge) begin
               new_game = 1'b1;
            end
         end
`ifdef GAME_LIVES_EN
         ST_RESPAWN: begin
            if (gif.frame_tick) begin
               state_d    = ST_COUNTDOWN;
               load_steps = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (new_game) begin
         state_d    = ST_COUNTDOWN;
         score_d    = '0;
         load_steps = 1'b1;
`ifdef GAME_LIVES_EN
         lives_d    = LIVES_INIT;
`endif
      end

      if (load_steps) begin
         step_d  = STEP_LOAD;
         frame_d = FRAME_RELOAD;
      end

      if (end_run) begin
`ifdef GAME_LIVES_EN
         if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = ST_RESPAWN;
         end else begin
            lives_d = 2'd0;
            go_over = 1'b1;
         end
`else
         go_over = 1'b1;
`endif
      end

      // best compares against the score including the final failing frame
      if (go_over) begin
         state_d = ST_OVER;
         best_d  = (score_d > best_q) ? score_d : best_q;
         hold_d  = HOLD_LOAD;
      end

      if (state_d != state_q) fail_d = '0;

      ball_rst_d   = !((state_d == ST_PLAY) || (state_d == ST_OVER));
      run_d        = (state_d == ST_PLAY);
      move_left_d  = (state_d == ST_PLAY) && gif.btn_left;
      move_right_d = (state_d == ST_PLAY) && gif.btn_right;
      countdown_d  = (state_d == ST_COUNTDOWN) ? step_d : 3'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         step_q       <= '0;
         frame_q      <= '0;
         fail_q       <= '0;
         hold_q       <= '0;
         score_q      <= '0;
         best_q       <= '0;
         lives_q      <= '0;
         ball_rst_q   <= 1'b1;
         run_q        <= 1'b0;
         move_left_q  <= 1'b0;
         move_right_q <= 1'b0;
         countdown_q  <= '0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         frame_q      <= frame_d;
         fail_q       <= fail_d;
         hold_q       <= hold_d;
         score_q      <= score_d;
         best_q       <= best_d;
         lives_q      <= lives_d;
         ball_rst_q   <= ball_rst_d;
         run_q        <= run_d;
         move_left_q  <= move_left_d;
         move_right_q <= move_right_d;
         countdown_q  <= countdown_d;
      end
   end

   assign gif.state      = state_q;
   assign gif.ball_rst   = ball_rst_q;
   assign gif.run        = run_q;
   assign gif.move_left  = move_left_q;
   assign gif.move_right = move_right_q;
   assign gif.countdown  = countdown_q;
   assign gif.score      = score_q;
   assign gif.best       = best_q;
   assign gif.lives      = lives_q;
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the ball datapath. It sequences each run through idle, countdown, play and game-over, and holds the ball datapath in reset outside play. It gates the player's left/right commands and turns the datapath's combinational `fail` flag into a debounced end-of-run decision. It keeps the run score and best score, and sits between the board buttons / frame timer and the ball control and scroll logic.

## Interface
Parameters:
- `FRAMES_PER_STEP`, 60: frame ticks per countdown step.
- `COUNT_STEPS`, 3: countdown steps shown before play; range 1..7.
- `FAIL_FRAMES`, 2: consecutive sampled frames with `fail` high that end a run; range 1..15.
- `OVER_HOLD_FRAMES`, 120: frames after game-over during which start is ignored.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `btn_start` in 1: level input; the internal rising edge starts a run.
- `btn_left`, `btn_right` in 1: raw player commands.
- `fail` in 1: ball over an empty block while grounded.
- `ball_rst` out 1: active-high reset to the ball datapath.
- `move_left`, `move_right` out 1: gated player commands.
- `run` out 1: scroll/advance enable.
- `state` out 3: current state encoding.
- `countdown` out 3: steps remaining; 0 outside COUNTDOWN.
- `score` out 16: frames survived in the current game.
- `best` out 16: highest score since reset.
- `lives` out 2: lives remaining.

## Operation
States and encodings: IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3, RESPAWN=4.

- **IDLE**
  - Outputs: `ball_rst`=1, `run`=0, moves forced 0.
  - Start edge → COUNTDOWN. Clear `score`. Load `lives`=3 (or 1 without the macro). Load step=COUNT_STEPS and frame count=FRAMES_PER_STEP-1.
- **COUNTDOWN**
  - Outputs: `ball_rst`=1, `countdown`=step.
  - On each `frame_tick`, decrement the frame count. At 0, reload it and decrement step.
  - step reaching 0 → PLAY.
- **PLAY**
  - Outputs: `ball_rst`=0, `run`=1, `move_*`=`btn_*`.
  - On each `frame_tick`:
    - `score`+1, saturating at 0xFFFF.
    - Sample `fail`: if high, fail count+1; if low, clear it.
  - Fail count reaching FAIL_FRAMES ends the run (see Configuration for the lives path).
  - Ending the run → OVER and `best`=max(`best`,`score`), both registered in the same cycle.
- **OVER**
  - Outputs: `ball_rst`=0, `run`=0, moves 0.
  - Hold counter counts `frame_tick`s up to OVER_HOLD_FRAMES.
  - Start edges are ignored until the hold completes. The first start edge after that → COUNTDOWN as a new game, with the same loads as from IDLE.
- **RESPAWN** (macro only)
  - Outputs: `ball_rst`=1, `run`=0.
  - On the next `frame_tick` → COUNTDOWN. Keep `score`; load the step and frame counters.

Start-edge rules:
- Edge detection uses a register of `btn_start` and is valid on any cycle.
- Start edges in COUNTDOWN, PLAY and RESPAWN are ignored.
- `fail` is ignored outside PLAY.
- The fail count clears on every state entry.

## Timing
- All outputs are registered. Reset (`rst`=0 at a clock edge) gives:
  - state=IDLE, `ball_rst`=1, `run`=0, moves 0, `countdown`=0, `score`=0, `best`=0, `lives`=0.
  - All counters at 0 and the edge register at 0.
- Start edge → `state`=1 on the following clock edge (1-cycle latency).
- A start edge and a `frame_tick` in the same cycle in IDLE: the transition is taken and the tick is not counted.
- Last countdown `frame_tick` → `run`=1 and `ball_rst`=0 on the next edge.
- Final failing `frame_tick` → `run`=0 on the next edge.
- `best` is valid in the same cycle that `state` reads OVER.
- `rst` asserted in any state overrides every transition in that cycle.

## Configuration
Macro: `GAME_LIVES_EN`.
- **Defined:** a run starts with `lives`=3.
  - Ending a run with `lives`>1 decrements `lives` and goes to RESPAWN.
  - Ending a run with `lives`=1 sets `lives`=0 and goes to OVER.
- **Undefined:** the RESPAWN state and lives counter are not built. `lives` outputs constant 1 after reset release (0 during reset). A run end always goes to OVER.

## Structure
- Package `game_pkg`:
  - state encodings;
  - `LIVES_INIT`=3;
  - score width 16 and the `SCORE_MAX` constant.
- One sub-module, `rise_detect` (clk, rst, in → one-cycle pulse), instantiated for `btn_start`.
- Everything else stays in `game_sequencer`.

## Test plan
The bench overrides FRAMES_PER_STEP=2, COUNT_STEPS=3, FAIL_FRAMES=2, OVER_HOLD_FRAMES=4.

- **Reset and start:** release `rst`, pulse `btn_start` → `state`=1 and `countdown`=3, then `countdown` 2, 1 after 2 ticks each, then `state`=2 with `run`=1 and `ball_rst`=0 after 6 ticks total.
- **Move gating:** `btn_left`=1 held through IDLE/COUNTDOWN → `move_left`=0; in PLAY → `move_left`=1.
- **Fail debounce:** in PLAY, `fail` high for 1 tick then low → stays PLAY. High for 2 ticks → `state`=3, `run`=0, `best`=`score`.
- **Start lockout:** start edge 2 ticks into OVER → ignored. Start edge after 4 ticks → COUNTDOWN with `score`=0.
- **Lives (macro defined):** three failures → `lives` 3→2→1→0, RESPAWN twice, then OVER. `score` is continuous across respawns.
- **Mid-run reset:** `rst`=0 in PLAY with `score`=10 → next edge gives `state`=0, `score`=0, `best`=0, `ball_rst`=1.
